interface_botoes: RTL
=====================

Name: interface_botoes

Overview:
- Input front-end between the board's raw active-low push-buttons and the game control unit.
- Per button: synchronises, debounces, and converts presses into single-cycle active-high pulses.
- Encodes the four play buttons into a one-hot jogada with a tem_jogada strobe, locking out further input until all play buttons are released.
- Adds auto-repeat on mais/menos.

Parameters:
- DEBOUNCE_CYCLES, 50000, consecutive cycles a new synchronised level must persist before it is accepted (D; must be >= 2).
- REPEAT_DELAY, 25000000, cycles from the accepted press of mais/menos to the first repeat pulse.
- REPEAT_PERIOD, 10000000, cycles between subsequent repeat pulses while held.
- CNT_W, 25, width of debounce and repeat counters; must hold max(D, REPEAT_DELAY, REPEAT_PERIOD).

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state
- botoes  in  4  raw play buttons, active-low (0 = pressed)
- jogar  in  1  raw, active-low
- confirma  in  1  raw, active-low
- mais  in  1  raw, active-low
- menos  in  1  raw, active-low
- jogar_p  out  1  one-cycle press pulse
- confirma_p  out  1  one-cycle press pulse
- mais_p  out  1  press/repeat pulse
- menos_p  out  1  press/repeat pulse
- tem_jogada  out  1  one-cycle strobe: valid single play-button press
- jogada  out  4  one-hot code of last accepted play button, held
- erro_multi  out  1  one-cycle strobe: simultaneous play-button presses
- db_niveis  out  8  debounced active-high levels {menos,mais,confirma,jogar,botoes[3:0]}

Behaviour:
- Reset (reset=0, async): synchronisers load "released", counters 0, FSM LIVRE, all outputs 0 (jogada=4'b0000).
- All 8 channels are identical.
  - Two-flop synchroniser on the inverted raw input gives s.
  - Stable level st with counter cnt.
  - If s==st: cnt<=0.
  - Else if cnt==D-1: st<=s, cnt<=0.
  - Else: cnt<=cnt+1.
- Press pulse p is registered: p<=(s && !st && cnt==D-1), so p rises on the same edge as st.
- Latency: new raw level first sampled at edge n and held → st/p change at edge n+D+1; p is high for exactly one cycle.
- Releases change st with the same latency and produce no pulse.
- A glitch or bounce shorter than D synchronised cycles resets cnt and is never seen.
- jogar_p = p(jogar); confirma_p = p(confirma).
- mais/menos auto-repeat, independent per channel, with its own repeat counter rc:
  - On p: output pulse, rc<=0.
  - While st=1: rc increments.
  - At rc==REPEAT_DELAY-1: pulse, then every REPEAT_PERIOD cycles thereafter.
  - st=0: rc<=0, no pulses.
- Play-button FSM:
  - LIVRE:
    - Exactly one botoes channel pulses → jogada<=its one-hot, tem_jogada=1 for one cycle, go TRAVADO.
    - Two or more pulse on the same edge → jogada unchanged, erro_multi=1 for one cycle, go TRAVADO.
  - TRAVADO: all play-button pulses ignored; when all four botoes st==0 → LIVRE on the next edge.
  - Press and release on the same edge cannot occur per channel; a pulse arriving on the edge TRAVADO→LIVRE is ignored.
- tem_jogada and erro_multi are registered outputs, asserted the cycle after the channel pulse.
- jogada stays valid until the next accepted press or reset.
- Reset mid-press: state cleared. A button still held after reset deasserts is treated as a new press and yields p after D+1 edges plus synchroniser delay.
- db_niveis = st of each channel, no extra delay.

Test Plan:
- D=4, delays 10/5. Hold botoes[2]=0 from edge 0 → db_niveis[2] rises at edge 5. tem_jogada=1 at edge 6 for one cycle. jogada=4'b0100 and holds after release.
- botoes[1] bounces 0/1 every 2 cycles for 20 cycles, then holds 1 → no tem_jogada, db_niveis[1] stays 0. Then a clean 10-cycle press → one tem_jogada, jogada=4'b0010.
- botoes[0] and botoes[3] pressed on the same edge → erro_multi single pulse, jogada unchanged. Press botoes[1] while [0] is still held → ignored. Release all, then press [1] → tem_jogada, jogada=4'b0010.
- Hold mais 40 cycles → mais_p at the press edge, at +10, then every 5 cycles (+15, +20…), 7 pulses total. Release → no more pulses.
- Hold jogar and confirma 20 cycles → exactly one jogar_p and one confirma_p, no repeats.
- Assert reset=0 asynchronously (between clock edges) mid-press with jogada=4'b1000 → all outputs 0 immediately. Button still held after reset=1 → new tem_jogada after latency.

Source files
------------

// File: rtl/interface_botoes.sv
// Button front-end: synchronises and debounces eight active-low raw buttons,
// turns presses into one-cycle pulses, adds auto-repeat on mais/menos and
// encodes the four play buttons into a one-hot jogada with a lockout FSM.
module interface_botoes #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 10000000,
    parameter int unsigned CNT_W           = 25
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] botoes,
    input  logic       jogar,
    input  logic       confirma,
    input  logic       mais,
    input  logic       menos,
    output logic       jogar_p,
    output logic       confirma_p,
    output logic       mais_p,
    output logic       menos_p,
    output logic       tem_jogada,
    output logic [3:0] jogada,
    output logic       erro_multi,
    output logic [7:0] db_niveis
);

    localparam logic [CNT_W-1:0] DB_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);

    typedef enum logic {
        LIVRE,
        TRAVADO
    } estado_t;

    // Channel order matches db_niveis: {menos, mais, confirma, jogar, botoes[3:0]}
    logic [7:0]       raw;
    logic [7:0]       sync1;
    logic [7:0]       sync2;
    logic [7:0]       st;
    logic [7:0]       p;
    logic [CNT_W-1:0] cnt [8];

    logic [1:0]       rep;
    logic [1:0]       first;
    logic [CNT_W-1:0] rc [2];

    estado_t          estado;
    estado_t          estado_next;
    logic             tem_next;
    logic             erro_next;
    logic [3:0]       jogada_next;

    assign raw = {menos, mais, confirma, jogar, botoes};

    // Two-flop synchroniser on the inverted (active-high) raw levels
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= ~raw;
            sync2 <= sync1;
        end
    end

    // Debounce: accept a new level after it persists D cycles; pulse on the rising acceptance
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            st <= '0;
            p  <= '0;
            for (int unsigned i = 0; i < 8; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 8; i++) begin
                p[i] <= sync2[i] && !st[i] && (cnt[i] == DB_LAST);
                if (sync2[i] == st[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == DB_LAST) begin
                    st[i]  <= sync2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + ONE;
                end
            end
        end
    end

    // Auto-repeat for mais/menos: first repeat after REPEAT_DELAY, then every REPEAT_PERIOD.
    // rc is already 0 on the press edge because st was low until then.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rep   <= '0;
            first <= '1;
            for (int unsigned j = 0; j < 2; j++) begin
                rc[j] <= '0;
            end
        end else begin
            for (int unsigned j = 0; j < 2; j++) begin
                rep[j] <= 1'b0;
                if (!st[6 + j]) begin
                    rc[j]    <= '0;
                    first[j] <= 1'b1;
                end else if (rc[j] == (first[j] ? DELAY_LAST : PERIOD_LAST)) begin
                    rep[j]   <= 1'b1;
                    rc[j]    <= '0;
                    first[j] <= 1'b0;
                end else begin
                    rc[j] <= rc[j] + ONE;
                end
            end
        end
    end

    // Play-button FSM next state and registered-output values
    always_comb begin
        estado_next = estado;
        tem_next    = 1'b0;
        erro_next   = 1'b0;
        jogada_next = jogada;
        case (estado)
            LIVRE: begin
                if ($onehot(p[3:0])) begin
                    tem_next    = 1'b1;
                    jogada_next = p[3:0];
                    estado_next = TRAVADO;
                end else if (|p[3:0]) begin
                    erro_next   = 1'b1;
                    estado_next = TRAVADO;
                end
            end
            TRAVADO: begin
                if (st[3:0] == 4'b0000) begin
                    estado_next = LIVRE;
                end
            end
            default: estado_next = LIVRE;
        endcase
    end

    // Play-button FSM state and output registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado     <= LIVRE;
            tem_jogada <= 1'b0;
            erro_multi <= 1'b0;
            jogada     <= '0;
        end else begin
            estado     <= estado_next;
            tem_jogada <= tem_next;
            erro_multi <= erro_next;
            jogada     <= jogada_next;
        end
    end

    assign jogar_p    = p[4];
    assign confirma_p = p[5];
    assign mais_p     = p[6] | rep[0];
    assign menos_p    = p[7] | rep[1];
    assign db_niveis  = st;

endmodule
